// File: rtl/edge_gate_pkg.sv
// Shared state encoding and widths for the edge-counter gate sequencer.
package edge_gate_pkg;

  localparam int WINDOW_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_TRIG,
    GATE,
    DONE
  } gate_state_t;

endpackage

// File: rtl/edge_gate_timer.sv
// Loadable down-counter timing one gate window; expire_o is high in the last run cycle.
// A zero load never expires and never wraps, giving an open-ended window.
module edge_gate_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n_sync,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         run_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i && (cnt_q == W'(1));

endmodule

// File: rtl/edge_counter_gate_sequencer.sv
// Runs edge-counter measurement windows: clear, optional trigger wait, G-cycle gate, snapshot.
// All outputs registered; start honoured only in IDLE/DONE, abort wins over everything.
module edge_counter_gate_sequencer
  import edge_gate_pkg::*;
#(
  parameter int GATE_W = 32,
  parameter int NUM_CH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n_sync,
  input  logic                    start,
  input  logic                    abort,
  input  logic [GATE_W-1:0]       cfg_gate_cycles,
  input  logic [NUM_CH-1:0]       cfg_chan_mask,
  input  logic                    cfg_use_trig,
  input  logic                    cfg_repeat,
  input  logic                    trig_in,
  output logic [NUM_CH-1:0]       enable,
  output logic                    clear_counts,
  output logic                    snapshot,
  output logic                    busy,
  output logic                    done,
  output logic [WINDOW_CNT_W-1:0] window_count
);

  gate_state_t       state_q;
  logic              trig_q;
  logic [GATE_W-1:0] gate_cycles_q;
  logic [NUM_CH-1:0] mask_q;
  logic              use_trig_q;
  logic              rpt_q;

  logic trig_edge;
  logic gate_enter;
  logic timer_expire;

  always_comb begin
    trig_edge  = trig_in & ~trig_q;
    gate_enter = 1'b0;
    if (state_q == CLEAR && clear_counts && !use_trig_q) begin
      gate_enter = 1'b1;
    end else if (state_q == WAIT_TRIG && trig_edge) begin
      gate_enter = 1'b1;
    end
  end

  edge_gate_timer #(.W(GATE_W)) u_timer (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .load_i     (gate_enter),
    .load_val_i (gate_cycles_q),
    .run_i      (state_q == GATE),
    .expire_o   (timer_expire)
  );

  // CLEAR entered straight from a repeat snapshot spends one extra cycle so the
  // clear pulse never overlaps the snapshot; CLEAR leaves once clear_counts has been shown.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q       <= IDLE;
      trig_q        <= 1'b0;
      gate_cycles_q <= '0;
      mask_q        <= '0;
      use_trig_q    <= 1'b0;
      rpt_q         <= 1'b0;
      enable        <= '0;
      clear_counts  <= 1'b0;
      snapshot      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      window_count  <= '0;
    end else begin
      trig_q       <= trig_in;
      clear_counts <= 1'b0;
      snapshot     <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        enable  <= '0;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              gate_cycles_q <= cfg_gate_cycles;
              mask_q        <= cfg_chan_mask;
              use_trig_q    <= cfg_use_trig;
              rpt_q         <= cfg_repeat;
              window_count  <= '0;
              state_q       <= CLEAR;
              clear_counts  <= 1'b1;
              busy          <= 1'b1;
              done          <= 1'b0;
            end
          end
          CLEAR: begin
            if (gate_enter) begin
              state_q <= GATE;
              enable  <= mask_q;
            end else if (clear_counts) begin
              state_q <= WAIT_TRIG;
            end else begin
              clear_counts <= 1'b1;
            end
          end
          WAIT_TRIG: begin
            if (gate_enter) begin
              state_q <= GATE;
              enable  <= mask_q;
            end
          end
          GATE: begin
            if (timer_expire) begin
              enable   <= '0;
              snapshot <= 1'b1;
              if (window_count != '1) begin
                window_count <= window_count + WINDOW_CNT_W'(1);
              end
              if (rpt_q) begin
                state_q <= CLEAR;
              end else begin
                state_q <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/edge_counter_gate_sequencer.md
# edge_counter_gate_sequencer

Sequences the edge counters through timed measurement windows. A start request latches the window configuration and clears the counters. The block optionally waits for an external trigger edge, then holds the selected counters' enables high for exactly the programmed number of clock cycles and emits a snapshot strobe. It sits between the SCARF register map, which supplies configuration and start/abort strobes, and the edge counter instances, whose enable inputs it drives.

## Interface
- `GATE_W`, 32: width of the gate-length counter.
- `NUM_CH`, 4: number of counter enables driven.
- `clk`  in  1  system clock.
- `rst_n_sync`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a run.
- `abort`  in  1  one-cycle request to stop immediately.
- `cfg_gate_cycles`  in  GATE_W  window length in clk cycles; 0 means open-ended.
- `cfg_chan_mask`  in  NUM_CH  counters enabled during the window.
- `cfg_use_trig`  in  1  wait for a `trig_in` rising edge before gating.
- `cfg_repeat`  in  1  run back-to-back windows until abort.
- `trig_in`  in  1  external trigger, already synchronous to `clk`.
- `enable`  out  NUM_CH  counter enables.
- `clear_counts`  out  1  one-cycle counter clear.
- `snapshot`  out  1  one-cycle strobe, end of window.
- `busy`  out  1  high in CLEAR, WAIT_TRIG and GATE.
- `done`  out  1  high while in DONE.
- `window_count`  out  16  completed windows since the last start; saturates at 16'hFFFF.

## Operation
- States: IDLE, CLEAR, WAIT_TRIG, GATE, DONE.
- `start` is accepted only in IDLE or DONE:
  - Latches `cfg_*` into shadow registers.
  - Zeroes `window_count`.
  - Goes to CLEAR.
- `start` in any other state is ignored.
- CLEAR lasts 1 cycle with `clear_counts` = 1. It then goes to WAIT_TRIG if the latched use_trig is set, otherwise to GATE.
- WAIT_TRIG:
  - `trig_q` registers `trig_in` every cycle.
  - Edge = `trig_in` & ~`trig_q`.
  - On an edge, go to GATE.
  - A level that is already high on entry does not trigger.
- GATE:
  - `enable` = latched mask, all other bits 0.
  - The down-counter loads the latched gate_cycles on entry.
  - Leave GATE after exactly gate_cycles cycles.
  - If gate_cycles = 0, stay in GATE until abort, with no snapshot.
- GATE exit: `snapshot` pulses 1 cycle and `window_count` increments (saturating).
  - If latched repeat = 1, go to CLEAR (a new window with the same config).
  - Otherwise go to DONE.
- DONE holds `enable` = 0 until `start` (goes to CLEAR) or `abort` (goes to IDLE).
- `abort` in any state goes to IDLE next cycle:
  - `enable` = 0.
  - No snapshot.
  - `window_count` is kept.
- `abort` and `start` in the same cycle: abort wins.
- Config changes after `start` have no effect until the next `start`.

## Timing
- All outputs are registered. Reset values:
  - `enable` = 0, `clear_counts` = 0, `snapshot` = 0.
  - `busy` = 0, `done` = 0, `window_count` = 0.
  - State = IDLE, `trig_q` = 0.
- Without trigger, `start` high in cycle N gives:
  - `clear_counts` high in N+1.
  - `enable` high in N+2 … N+1+G.
  - `snapshot` high in N+2+G.
  - `done` high from N+2+G.
- With trigger, an edge seen in cycle T gives `enable` high in T+1 … T+G and `snapshot` in T+G+1.
- Repeat mode: `snapshot` and `clear_counts` never overlap. Each window is snapshot (1 cycle), then CLEAR (1 cycle), then trigger wait or gate.
- G = 1 gives a single-cycle enable. G = 2^GATE_W−1 must not wrap.
- Reset mid-run forces all outputs to reset values asynchronously.

## Structure
- Package `edge_gate_pkg` holds:
  - the `gate_state_t` enum (IDLE, CLEAR, WAIT_TRIG, GATE, DONE);
  - `WINDOW_CNT_W` = 16.
- One sub-module, `edge_gate_timer`: a loadable GATE_W down-counter with load, run and expire. It asserts expire in the last gate cycle.
- The FSM, trigger edge detect, shadow config and window counter live in the top module.

## Test plan
- mask = 4'b0101, G = 5, no trig; pulse `start`. Expect:
  - `clear_counts` 1 cycle;
  - `enable` = 4'b0101 for exactly 5 cycles;
  - `snapshot` 1 cycle later;
  - `done` = 1 and `window_count` = 1.
- use_trig = 1, G = 3, `trig_in` held high before `start`:
  - no gating while it stays high;
  - after a low→high edge, `enable` is high for 3 cycles and then `snapshot` pulses.
- repeat = 1, G = 2. Check:
  - the cyclic pattern snapshot, clear, 2 enable cycles;
  - `abort` after 3 windows: `enable` = 0 next cycle, `window_count` = 3, no further snapshot.
- G = 0: `enable` stays high for 1000 cycles with no `snapshot`; `abort` returns to IDLE with `busy` = 0.
- `start` during GATE is ignored, and a config change mid-window has no effect. `start` and `abort` in the same cycle in IDLE leave the block in IDLE.
- Assert `rst_n_sync` low mid-GATE: all outputs reach reset values without waiting for a clock edge. After release, a normal run completes.
